// File: rtl/round_key_sequencer.sv
// round_key_sequencer: captures the NK generated round keys into a local bank
// and issues them one per round over a valid/ready handshake, forward order
// for encryption and reverse order for decryption.
// Optional build macro RKSEQ_ZERO_KEY_CHK_EN: reject key loads that contain
// an all-zero key and report it on o_key_err (tied 0 when undefined).
//
// Handshake: o_rk/o_rk_round are meaningful while o_rk_vld is high; a key is
// transferred on a rising edge where o_rk_vld & i_rk_rdy; while i_rk_rdy is
// low the offered key, round and valid hold stable with no timeout.
//
// o_dbg_state encoding: 0 = S_EMPTY, 1 = S_READY, 2 = S_ISSUE.
module round_key_sequencer #(
  parameter int KW = 128,
  parameter int NK = 11
) (
  input  logic             clk,
  input  logic             rst_an,
  input  logic             i_keys_ready,
  input  logic [NK*KW-1:0] i_keys_in,
  input  logic             i_start,
  input  logic             i_dec,
  output logic [KW-1:0]    o_rk,
  output logic             o_rk_vld,
  input  logic             i_rk_rdy,
  output logic [3:0]       o_rk_round,
  output logic             o_rk_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_key_err,
  output logic [1:0]       o_dbg_state
);

  localparam int IW = 4;
  localparam logic [IW-1:0] LAST = IW'(NK - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_READY = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t        r_state;
  logic [KW-1:0] r_bank [NK];
  logic [IW-1:0] r_idx;
  logic          r_dec;
  logic [KW-1:0] r_rk;
  logic          r_rk_vld;
  logic [IW-1:0] r_round;
  logic          r_busy;
  logic          r_done;
  logic          r_key_err;

  logic [KW-1:0] w_keys [NK];
  logic          w_zero_key;
  logic          w_load_ok;
  logic          w_load_bad;
  logic          w_xfer;
  logic [IW-1:0] w_next_idx;
  logic [IW-1:0] w_start_idx;

  // Split the concatenated generator bus: key1 sits in the top KW bits.
  always_comb begin
    for (int k = 0; k < NK; k++) begin
      w_keys[k] = i_keys_in[(NK-k)*KW-1 -: KW];
    end
  end

`ifdef RKSEQ_ZERO_KEY_CHK_EN
  // Flag a load that carries any all-zero round key.
  always_comb begin
    w_zero_key = 1'b0;
    for (int k = 0; k < NK; k++) begin
      if (w_keys[k] == '0) w_zero_key = 1'b1;
    end
  end
`else
  assign w_zero_key = 1'b0;
`endif

  assign w_load_ok   = i_keys_ready & ~w_zero_key;
  assign w_load_bad  = i_keys_ready & w_zero_key;
  assign w_xfer      = r_rk_vld & i_rk_rdy;
  assign w_next_idx  = r_dec ? (r_idx - IW'(1)) : (r_idx + IW'(1));
  assign w_start_idx = i_dec ? LAST : '0;

  // Sequencer FSM: bank capture, key issue and completion, all registered.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_state   <= S_EMPTY;
      for (int k = 0; k < NK; k++) r_bank[k] <= '0;
      r_idx     <= '0;
      r_dec     <= 1'b0;
      r_rk      <= '0;
      r_rk_vld  <= 1'b0;
      r_round   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_key_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_EMPTY: begin
          if (w_load_ok) begin
            for (int k = 0; k < NK; k++) r_bank[k] <= w_keys[k];
            r_key_err <= 1'b0;
            r_state   <= S_READY;
          end else if (w_load_bad) begin
            r_key_err <= 1'b1;
          end
        end
        S_READY: begin
          if (w_load_bad) begin
            // A rejected load invalidates the bank; no sequence may start.
            r_key_err <= 1'b1;
            r_state   <= S_EMPTY;
          end else begin
            if (w_load_ok) begin
              for (int k = 0; k < NK; k++) r_bank[k] <= w_keys[k];
              r_key_err <= 1'b0;
            end
            if (i_start) begin
              // Reads the bank as held before this edge: old keys win.
              r_idx    <= w_start_idx;
              r_dec    <= i_dec;
              r_rk     <= r_bank[w_start_idx];
              r_round  <= '0;
              r_rk_vld <= 1'b1;
              r_busy   <= 1'b1;
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_xfer) begin
            if (r_round == LAST) begin
              r_rk_vld <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_round  <= '0;
              r_state  <= S_READY;
            end else begin
              r_idx   <= w_next_idx;
              r_rk    <= r_bank[w_next_idx];
              r_round <= r_round + IW'(1);
            end
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign o_rk        = r_rk;
  assign o_rk_vld    = r_rk_vld;
  assign o_rk_round  = r_round;
  assign o_rk_last   = r_rk_vld & (r_round == LAST);
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_key_err   = r_key_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Bench for round_key_sequencer: directed key sets, expected keys pushed into
// a queue when a sequence is started, popped by a monitor on each transfer.
module tb_round_key_sequencer;

  localparam int KW = 128;
  localparam int NK = 11;
  localparam int EW = KW + 5;

  logic             clk;
  logic             rst_an;
  logic             i_keys_ready;
  logic [NK*KW-1:0] i_keys_in;
  logic             i_start;
  logic             i_dec;
  logic [KW-1:0]    o_rk;
  logic             o_rk_vld;
  logic             i_rk_rdy;
  logic [3:0]       o_rk_round;
  logic             o_rk_last;
  logic             o_busy;
  logic             o_done;
  logic             o_key_err;
  logic [1:0]       o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Expected transfers: {rk, round, last}.
  logic [EW-1:0] exp_q[$];

  round_key_sequencer #(.KW(KW), .NK(NK)) dut (
    .clk(clk), .rst_an(rst_an), .i_keys_ready(i_keys_ready),
    .i_keys_in(i_keys_in), .i_start(i_start), .i_dec(i_dec),
    .o_rk(o_rk), .o_rk_vld(o_rk_vld), .i_rk_rdy(i_rk_rdy),
    .o_rk_round(o_rk_round), .o_rk_last(o_rk_last), .o_busy(o_busy),
    .o_done(o_done), .o_key_err(o_key_err), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // key_n = {16{base+n}}; key zero_idx (1-based) forced to zero if nonzero.
  function automatic logic [NK*KW-1:0] make_keys(input logic [7:0] base, input int zero_idx);
    logic [NK*KW-1:0] v;
    logic [7:0] b;
    v = '0;
    for (int n = 1; n <= NK; n++) begin
      b = base + 8'(n);
      v[(NK-n+1)*KW-1 -: KW] = (n == zero_idx) ? {KW{1'b0}} : {16{b}};
    end
    return v;
  endfunction

  // Monitor / scoreboard: pop on every transfer, verify holds during stalls.
  logic          prev_stall = 1'b0;
  logic [KW+4:0] saved;
  always @(negedge clk) begin
    if (!rst_an) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {o_rk, o_rk_round, o_rk_vld}, saved);
      if (o_rk_vld && i_rk_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", {o_rk, o_rk_round, o_rk_last}, '0);
        end else begin
          check("xfer", {o_rk, o_rk_round, o_rk_last}, exp_q.pop_front());
        end
      end
      prev_stall = o_rk_vld & ~i_rk_rdy;
      saved = {o_rk, o_rk_round, o_rk_vld};
    end
  end

  task automatic pulse_start(input logic d);
    @(posedge clk); #2;
    i_start = 1'b1;
    i_dec   = d;
    @(posedge clk); #2;
    i_start = 1'b0;
  endtask

  // Driver: one full sequence. mode 0 = rdy held high, 1 = rdy 1-0-1-0.
  // disturb: change keys and pulse start mid-sequence (must be ignored).
  // abort_at >= 0: assert reset after that many cycles.
  task automatic run_seq(input logic d, input int mode, input int abort_at,
                         input int exp_cycles, input logic [NK*KW-1:0] kexp,
                         input bit disturb);
    int  cyc;
    bit  done_seen;
    int  idx;
    for (int r = 0; r < NK; r++) begin
      idx = d ? (NK - 1 - r) : r;
      exp_q.push_back({kexp[(NK-idx)*KW-1 -: KW], 4'(r), (r == NK - 1)});
    end
    i_rk_rdy = 1'b0;
    pulse_start(d);
    check("vld_after_start", {o_rk_vld, o_busy}, 2'b11);
    cyc = 0;
    done_seen = 0;
    while (cyc < 100 && !done_seen) begin
      i_rk_rdy = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      if (disturb && cyc == 3) begin
        i_keys_in = make_keys(8'h20, 0);
        i_start   = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk); #2;
      cyc++;
      if (abort_at >= 0 && cyc == abort_at) begin
        rst_an = 1'b0;
        #1;
        check("abort_outputs", {o_rk_vld, o_busy, o_rk, o_rk_round, o_done}, '0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_an = 1'b1;
        i_rk_rdy = 1'b0;
        return;
      end
      if (o_done) done_seen = 1;
    end
    i_start = 1'b0;
    check("done_seen", done_seen, 1'b1);
    check("seq_cycles", cyc, exp_cycles);
    check("end_flags", {o_busy, o_rk_vld, o_rk_last}, 3'b000);
    check("queue_drained", exp_q.size(), 0);
    i_rk_rdy = 1'b0;
    @(posedge clk); #2;
    check("done_one_cycle", o_done, 1'b0);
  endtask

  initial begin
    logic [NK*KW-1:0] k1;
    logic [NK*KW-1:0] k2;
    k1 = make_keys(8'h00, 0);
    k2 = make_keys(8'h20, 0);
    rst_an = 1'b0;
    i_keys_ready = 1'b0;
    i_keys_in = '0;
    i_start = 1'b0;
    i_dec = 1'b0;
    i_rk_rdy = 1'b0;
    #3;
    check("reset_outputs", {o_rk, o_rk_vld, o_rk_round, o_rk_last, o_busy, o_done, o_key_err}, '0);
    check("reset_state", o_dbg_state, 2'd0);
    #19 rst_an = 1'b1;

    // Start in S_EMPTY is ignored.
    pulse_start(1'b0);
    @(posedge clk); #2;
    check("start_ignored_empty", {o_rk_vld, o_busy, o_dbg_state}, 4'b0000);

    // Load first key set; it stays presented at level.
    i_keys_ready = 1'b1;
    i_keys_in = k1;
    run_seq(1'b0, 0, -1, 11, k1, 1'b0);
    check("state_ready", o_dbg_state, 2'd1);
    run_seq(1'b1, 0, -1, 11, k1, 1'b0);
    run_seq(1'b0, 1, -1, 21, k1, 1'b0);
    // New keys + start mid-sequence: ignored now, used by the next sequence.
    run_seq(1'b0, 0, -1, 11, k1, 1'b1);
    run_seq(1'b1, 0, -1, 11, k2, 1'b0);
    check("key_err_off", o_key_err, 1'b0);

    // Abort after the 5th transfer, then start without keys.
    run_seq(1'b0, 0, 5, 0, k2, 1'b0);
    i_keys_ready = 1'b0;
    pulse_start(1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("no_vld_after_reset", {o_rk_vld, o_busy, o_dbg_state}, 4'b0000);

`ifdef RKSEQ_ZERO_KEY_CHK_EN
    i_keys_in = make_keys(8'h00, 6);
    i_keys_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("zero_key_err", {o_key_err, o_dbg_state}, 3'b100);
    pulse_start(1'b0);
    @(posedge clk); #2;
    check("zero_key_start_ignored", {o_rk_vld, o_busy}, 2'b00);
    i_keys_in = k1;
    run_seq(1'b0, 0, -1, 11, k1, 1'b0);
    check("zero_key_cleared", o_key_err, 1'b0);
`else
    i_keys_in = make_keys(8'h00, 6);
    i_keys_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("no_chk_key_err", {o_key_err, o_dbg_state}, 3'b001);
    run_seq(1'b0, 0, -1, 11, make_keys(8'h00, 6), 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/round_key_sequencer.md
Name: round_key_sequencer

Overview:
- Sits directly downstream of the LFSR round-key generator and upstream of the AES round datapath.
- Captures the 11 generated 128-bit round keys into a local bank.
- Issues them one per round over a valid/ready handshake: forward order (key1..key11) for encryption, reverse order (key11..key1) for decryption.
- Tracks round number, marks the last key and signals completion.

Parameters:
- KW, 128, round-key width in bits.
- NK, 11, number of round keys (Nr+1 for AES-128).

Ports:
- clk  in  1  clock, rising edge.
- rst_an  in  1  reset, asynchronous, active-low.
- keys_ready  in  1  generator keys stable and valid (level).
- keys_in  in  NK*KW  concatenated keys; key1 at [NK*KW-1 -: KW], key11 at [KW-1:0].
- start  in  1  single-cycle request to begin a key sequence.
- dec  in  1  direction sampled with start: 0 = forward, 1 = reverse.
- rk  out  KW  current round key (registered).
- rk_vld  out  1  rk valid.
- rk_rdy  in  1  consumer accepts rk.
- rk_round  out  4  round number of rk, 0..NK-1, counts up in both directions.
- rk_last  out  1  high with rk_vld when rk_round == NK-1.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse after last key accepted.
- key_err  out  1  see Optional Feature; 0 when the feature is compiled out.

Behaviour:
- Reset values (async, rst_an low): state = S_EMPTY; bank cleared to 0; rk = 0; rk_vld = 0; rk_round = 0; rk_last = 0; busy = 0; done = 0; key_err = 0; internal index idx = 0.
- S_EMPTY:
  - keys_ready = 1 at a clock edge → bank[0..NK-1] <= keys_in, go to S_READY.
  - start is ignored.
- S_READY:
  - While keys_ready = 1, bank recaptures keys_in every cycle (tracks regeneration).
  - start = 1 → idx <= (dec ? NK-1 : 0); rk <= bank[that idx]; rk_round <= 0; rk_vld <= 1; busy <= 1; go to S_ISSUE.
  - Latency: start at edge N gives rk_vld = 1 after edge N.
  - start and keys_ready together: the load happens on the same edge, but rk takes the bank value held before that edge (old keys). The new keys apply to the next sequence.
- S_ISSUE:
  - rk, rk_vld and rk_round hold stable while rk_rdy = 0; no timeout.
  - Transfer = rk_vld & rk_rdy.
  - Transfer with rk_round < NK-1: idx <= idx ± 1 (+ forward, − reverse); rk <= next bank entry; rk_round <= rk_round + 1; rk_vld stays 1. Zero bubbles: NK keys take NK cycles when rk_rdy is held high.
  - Transfer with rk_round == NK-1: rk_vld <= 0; busy <= 0; done <= 1 for one cycle; rk_round <= 0; go to S_READY. rk keeps its last value.
  - keys_ready and start are ignored; the bank is frozen during S_ISSUE.
- rk_last = rk_vld & (rk_round == NK-1). It is combinational from registers.
- idx never wraps: it covers exactly 0..NK-1 in either direction.
- Reset mid-sequence aborts immediately: all outputs return to reset values and the keys must be reloaded.

Optional Feature:
- Macro: RKSEQ_ZERO_KEY_CHK_EN.
- Defined:
  - On every load edge (S_EMPTY or S_READY), if any KW-bit key in keys_in is all zero, the bank is not written and key_err <= 1.
  - State forces to S_EMPTY; start is ignored until a clean load.
  - A clean load clears key_err and proceeds as normal.
- Undefined: no check is performed and key_err is tied 0.

Test Plan:
- Reset, then keys_ready = 1 with key_n = {16{8'(n)}} (key1 = 0101…01, key11 = 0b0b…0b), start = 1, dec = 0, rk_rdy held 1 → rk = key1..key11 on 11 consecutive cycles; rk_round = 0..10; rk_last only with key11; done pulses 1 cycle after; busy falls with done.
- Same keys, dec = 1 → rk order key11 (0b…0b) first, key1 (01…01) last; rk_round still counts 0..10.
- rk_rdy toggled 1-0-1-0 during the sequence → rk holds through each stall; all 11 keys delivered once, none skipped or duplicated; 21 cycles from first rk_vld to done.
- keys_in changed to a new set and start pulsed while in S_ISSUE → ignored; current sequence completes with the old keys. After done, the next start issues the new keys.
- rst_an low after the 5th transfer → rk_vld = 0, busy = 0, rk = 0 immediately; start after reset with keys_ready = 0 yields no rk_vld.
- With RKSEQ_ZERO_KEY_CHK_EN defined, key6 = 0 loaded → key_err = 1, start ignored; reload with key6 = 06…06 → key_err = 0 and the sequence runs normally.
